// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states and transaction owner.
package sdram_arb_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} arb_state_t;
   typedef enum logic       {OWN_VID, OWN_CPU}     arb_owner_t;

endpackage

// File: rtl/sdram_arb_select.sv
// Combinational owner decision: video has priority unless the CPU has been
// passed over for MAX_VID_RUN consecutive video grants.
module sdram_arb_select
   import sdram_arb_pkg::*;
#(
   parameter int MAX_VID_RUN = 8,
   parameter int CW          = $clog2(MAX_VID_RUN + 1)
) (
   input  logic          i_vid_req,
   input  logic          i_cpu_req,
   input  logic [CW-1:0] i_starve_cnt,
   output logic          o_grant,
   output arb_owner_t    o_owner
);

   logic w_starved;

   assign w_starved = (i_starve_cnt == CW'(MAX_VID_RUN));
   assign o_grant   = i_vid_req | i_cpu_req;
   assign o_owner   = (i_cpu_req && (!i_vid_req || w_starved)) ? OWN_CPU : OWN_VID;

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM controller arbiter: video (high priority) vs CPU, one full
// req/ack transaction at a time, with a starvation bound for the CPU.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 24,
   parameter int DATA_WIDTH  = 32,
   parameter int MAX_VID_RUN = 8
) (
   input  logic                    clk,
   input  logic                    reset_n_i,
   input  logic                    vid_req_i,
   input  logic [ADDR_WIDTH-1:0]   vid_addr_i,
   output logic                    vid_ack_o,
   output logic [DATA_WIDTH-1:0]   vid_rdata_o,
   input  logic                    cpu_req_i,
   input  logic                    cpu_we_i,
   input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
   input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] cpu_be_i,
   output logic                    cpu_ack_o,
   output logic [DATA_WIDTH-1:0]   cpu_rdata_o,
   output logic                    ctrl_req_o,
   output logic                    ctrl_we_o,
   output logic [ADDR_WIDTH-1:0]   ctrl_addr_o,
   output logic [DATA_WIDTH-1:0]   ctrl_wdata_o,
   output logic [DATA_WIDTH/8-1:0] ctrl_be_o,
   input  logic                    ctrl_ack_i,
   input  logic [DATA_WIDTH-1:0]   ctrl_rdata_i
);

   localparam int CW = $clog2(MAX_VID_RUN + 1);

   arb_state_t    r_state;
   arb_owner_t    r_owner;
   logic [CW-1:0] r_starve_cnt;

   logic          w_grant;
   arb_owner_t    w_owner;

   sdram_arb_select #(
      .MAX_VID_RUN (MAX_VID_RUN),
      .CW          (CW)
   ) u_select (
      .i_vid_req    (vid_req_i),
      .i_cpu_req    (cpu_req_i),
      .i_starve_cnt (r_starve_cnt),
      .o_grant      (w_grant),
      .o_owner      (w_owner)
   );

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state      <= IDLE;
         r_owner      <= OWN_VID;
         r_starve_cnt <= '0;
         ctrl_req_o   <= 1'b0;
         ctrl_we_o    <= 1'b0;
         ctrl_addr_o  <= '0;
         ctrl_wdata_o <= '0;
         ctrl_be_o    <= '0;
         vid_ack_o    <= 1'b0;
         cpu_ack_o    <= 1'b0;
         vid_rdata_o  <= '0;
         cpu_rdata_o  <= '0;
      end else begin
         vid_ack_o <= 1'b0;
         cpu_ack_o <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_owner    <= w_owner;
                  ctrl_req_o <= 1'b1;
                  r_state    <= BUSY;
                  if (w_owner == OWN_CPU) begin
                     ctrl_we_o    <= cpu_we_i;
                     ctrl_addr_o  <= cpu_addr_i;
                     ctrl_wdata_o <= cpu_wdata_i;
                     ctrl_be_o    <= cpu_be_i;
                     r_starve_cnt <= '0;
                  end else begin
                     ctrl_we_o   <= 1'b0;
                     ctrl_addr_o <= vid_addr_i;
                     ctrl_be_o   <= '1;
                     // Only count video wins that actually kept the CPU waiting.
                     if (!cpu_req_i)
                        r_starve_cnt <= '0;
                     else if (r_starve_cnt != CW'(MAX_VID_RUN))
                        r_starve_cnt <= r_starve_cnt + CW'(1);
                  end
               end
            end
            BUSY: begin
               if (ctrl_ack_i) begin
                  ctrl_req_o <= 1'b0;
                  r_state    <= RELEASE;
                  if (r_owner == OWN_CPU) begin
                     cpu_ack_o   <= 1'b1;
                     cpu_rdata_o <= ctrl_rdata_i;
                  end else begin
                     vid_ack_o   <= 1'b1;
                     vid_rdata_o <= ctrl_rdata_i;
                  end
               end
            end
            // Gives the requester a cycle to drop req so it is not re-granted.
            RELEASE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_sdram_arbiter;

   localparam int AW   = 24;
   localparam int DW   = 32;
   localparam int MAXR = 8;

   logic          clk = 1'b0;
   logic          reset_n_i = 1'b0;
   logic          vid_req_i = 1'b0;
   logic [AW-1:0] vid_addr_i = '0;
   logic          vid_ack_o;
   logic [DW-1:0] vid_rdata_o;
   logic          cpu_req_i = 1'b0;
   logic          cpu_we_i = 1'b0;
   logic [AW-1:0] cpu_addr_i = '0;
   logic [DW-1:0] cpu_wdata_i = '0;
   logic [3:0]    cpu_be_i = '0;
   logic          cpu_ack_o;
   logic [DW-1:0] cpu_rdata_o;
   logic          ctrl_req_o;
   logic          ctrl_we_o;
   logic [AW-1:0] ctrl_addr_o;
   logic [DW-1:0] ctrl_wdata_o;
   logic [3:0]    ctrl_be_o;
   logic          ctrl_ack_i = 1'b0;
   logic [DW-1:0] ctrl_rdata_i = '0;

   int total = 0;
   int bad   = 0;

   sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_VID_RUN(MAXR)) dut (
      .clk(clk), .reset_n_i(reset_n_i),
      .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i),
      .vid_ack_o(vid_ack_o), .vid_rdata_o(vid_rdata_o),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_wdata_i(cpu_wdata_i), .cpu_be_i(cpu_be_i),
      .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o),
      .ctrl_req_o(ctrl_req_o), .ctrl_we_o(ctrl_we_o), .ctrl_addr_o(ctrl_addr_o),
      .ctrl_wdata_o(ctrl_wdata_o), .ctrl_be_o(ctrl_be_o),
      .ctrl_ack_i(ctrl_ack_i), .ctrl_rdata_i(ctrl_rdata_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_own: 0 none, 1 video, 2 cpu. m_cool: idle cycles owed after a completion.
   // m_run: video grants in a row that kept a requesting CPU waiting.
   int            m_own, m_cool, m_run;
   logic          e_creq, e_we, e_vack, e_cack;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_vrd, e_crd;
   logic [3:0]    e_be;
   wire           m_cpu_turn = cpu_req_i && (!vid_req_i || m_run >= MAXR);

   always @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         m_own <= 0; m_cool <= 0; m_run <= 0;
         e_creq <= 0; e_we <= 0; e_vack <= 0; e_cack <= 0;
         e_addr <= '0; e_wdata <= '0; e_vrd <= '0; e_crd <= '0; e_be <= '0;
      end else begin
         e_vack <= 0;
         e_cack <= 0;
         if (m_own != 0) begin
            if (ctrl_ack_i) begin
               e_creq <= 0;
               m_own  <= 0;
               m_cool <= 1;
               if (m_own == 1) begin e_vack <= 1; e_vrd <= ctrl_rdata_i; end
               else            begin e_cack <= 1; e_crd <= ctrl_rdata_i; end
            end
         end else if (m_cool != 0) begin
            m_cool <= m_cool - 1;
         end else if (vid_req_i || cpu_req_i) begin
            e_creq <= 1;
            if (m_cpu_turn) begin
               m_own <= 2; m_run <= 0;
               e_we <= cpu_we_i; e_addr <= cpu_addr_i; e_wdata <= cpu_wdata_i; e_be <= cpu_be_i;
            end else begin
               m_own <= 1;
               m_run <= cpu_req_i ? ((m_run < MAXR) ? m_run + 1 : MAXR) : 0;
               e_we <= 0; e_addr <= vid_addr_i; e_be <= 4'hF;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (reset_n_i) begin
         chk("ctrl_req", ctrl_req_o, e_creq);
         chk("vid_ack", vid_ack_o, e_vack);
         chk("cpu_ack", cpu_ack_o, e_cack);
         chk("vid_rdata", vid_rdata_o, e_vrd);
         chk("cpu_rdata", cpu_rdata_o, e_crd);
         if (e_creq) begin
            chk("ctrl_we", ctrl_we_o, e_we);
            chk("ctrl_addr", ctrl_addr_o, e_addr);
            chk("ctrl_wdata", ctrl_wdata_o, e_wdata);
            chk("ctrl_be", ctrl_be_o, e_be);
         end
      end
   end

   // ---------------- SDRAM controller responder ----------------
   int            lat = 4;
   int            rsp_cnt = 0;
   logic          spur = 1'b0;
   logic [DW-1:0] dflt = 32'hA000_0000;
   logic [DW-1:0] rdq[$];

   always @(negedge clk) begin
      ctrl_ack_i = 1'b0;
      if (!reset_n_i) begin
         rsp_cnt = 0;
      end else if (ctrl_req_o) begin
         rsp_cnt++;
         if (rsp_cnt >= lat) begin
            ctrl_ack_i = 1'b1;
            if (rdq.size() > 0) ctrl_rdata_i = rdq.pop_front();
            else begin ctrl_rdata_i = dflt; dflt = dflt + 1; end
            rsp_cnt = 0;
         end
      end else if (spur) begin
         ctrl_ack_i   = 1'b1;
         ctrl_rdata_i = 32'hBADB_AD00;
      end
   end

   // ---------------- requester side ----------------
   logic          vid_hold = 1'b0, cpu_hold = 1'b0, prev_creq = 1'b0;
   byte           glog[$];
   logic [DW-1:0] vlog[$], clog[$];

   task automatic step();
      @(negedge clk);
      if (ctrl_req_o && !prev_creq) glog.push_back((ctrl_addr_o == vid_addr_i) ? "V" : "C");
      prev_creq = ctrl_req_o;
      if (vid_ack_o) begin vlog.push_back(vid_rdata_o); if (!vid_hold) vid_req_i = 1'b0; end
      if (cpu_ack_o) begin clog.push_back(cpu_rdata_o); if (!cpu_hold) cpu_req_i = 1'b0; end
   endtask

   task automatic cpu_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d; cpu_be_i = 4'hF; cpu_req_i = 1'b1;
   endtask

   initial begin
      int k;
      int nv, nc;
      logic ok;

      // reset state
      repeat (3) step();
      chk("rst_ctrl_req", ctrl_req_o, 0);
      chk("rst_ctrl_addr", ctrl_addr_o, 0);
      chk("rst_ctrl_be", ctrl_be_o, 0);
      chk("rst_cpu_rdata", cpu_rdata_o, 0);
      chk("rst_vid_ack", vid_ack_o, 0);
      reset_n_i = 1'b1;
      step();

      // single CPU write, controller latency 4
      lat = 4;
      cpu_cmd(1'b1, 24'h000100, 32'hDEAD_BEEF);
      rdq.push_back(32'h5555_AAAA);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin step(); ok = ctrl_req_o; end
      chk("t1_granted", ok, 1);
      chk("t1_addr", ctrl_addr_o, 24'h000100);
      chk("t1_wdata", ctrl_wdata_o, 32'hDEAD_BEEF);
      chk("t1_be", ctrl_be_o, 4'hF);
      chk("t1_we", ctrl_we_o, 1);
      k = 0; ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin step(); k++; ok = cpu_ack_o; end
      chk("t1_ack_seen", ok, 1);
      chk("t1_ack_latency", k, 4);
      chk("t1_wr_rdata", cpu_rdata_o, 32'h5555_AAAA);
      step();
      chk("t1_ack_one_cycle", cpu_ack_o, 0);
      chk("t1_no_vid_ack", vlog.size(), 0);
      repeat (3) step();

      // simultaneous video + CPU read
      glog.delete(); vlog.delete(); clog.delete();
      lat = 3;
      rdq.push_back(32'h1111_1111); rdq.push_back(32'h2222_2222);
      vid_addr_i = 24'h000200; vid_req_i = 1'b1;
      cpu_cmd(1'b0, 24'h000300, 32'h0);
      for (int i = 0; i < 60 && (vid_req_i || cpu_req_i); i++) step();
      chk("t2_done", {vid_req_i, cpu_req_i}, 2'b00);
      repeat (3) step();
      chk("t2_ngrants", glog.size(), 2);
      if (glog.size() == 2) begin
         chk("t2_first_vid", glog[0], "V");
         chk("t2_second_cpu", glog[1], "C");
      end
      if (vlog.size() > 0) chk("t2_vid_data", vlog[0], 32'h1111_1111);
      else chk("t2_vid_acked", vlog.size(), 1);
      if (clog.size() > 0) chk("t2_cpu_data", clog[0], 32'h2222_2222);
      else chk("t2_cpu_acked", clog.size(), 1);

      // starvation bound with both requesters held high
      reset_n_i = 1'b0; step(); reset_n_i = 1'b1; step();
      glog.delete();
      lat = 1; vid_hold = 1'b1; cpu_hold = 1'b1;
      vid_addr_i = 24'h000A00; vid_req_i = 1'b1;
      cpu_cmd(1'b0, 24'h000C00, 32'h0);
      for (int i = 0; i < 300 && glog.size() < 18; i++) step();
      vid_req_i = 1'b0; cpu_req_i = 1'b0; vid_hold = 1'b0; cpu_hold = 1'b0;
      repeat (8) step();
      chk("t3_ngrants", glog.size(), 18);
      nv = 0; nc = 0;
      for (int i = 0; i < 18 && i < glog.size(); i++) begin
         if (i == 8 || i == 17) begin nc++; chk($sformatf("t3_grant%0d_cpu", i), glog[i], "C"); end
         else begin nv++; chk($sformatf("t3_grant%0d_vid", i), glog[i], "V"); end
      end

      // stale req held one cycle past the ack
      glog.delete(); clog.delete();
      lat = 2; cpu_hold = 1'b1;
      rdq.push_back(32'h3333_3333);
      cpu_cmd(1'b0, 24'h000400, 32'h0);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin step(); ok = cpu_ack_o; end
      chk("t4_acked", ok, 1);
      step();
      cpu_req_i = 1'b0; cpu_hold = 1'b0;
      repeat (6) step();
      chk("t4_single_grant", glog.size(), 1);
      chk("t4_rdata", cpu_rdata_o, 32'h3333_3333);

      // spurious controller ack while idle
      nv = vlog.size(); nc = clog.size();
      @(posedge clk); spur = 1'b1;
      step(); spur = 1'b0;
      repeat (3) step();
      chk("t5_no_vid_ack", vlog.size(), nv);
      chk("t5_no_cpu_ack", clog.size(), nc);
      chk("t5_cpu_rdata_kept", cpu_rdata_o, 32'h3333_3333);
      chk("t5_no_req", ctrl_req_o, 0);

      // asynchronous reset in the middle of a CPU transaction
      lat = 10; nc = clog.size();
      cpu_cmd(1'b1, 24'h000500, 32'hCAFE_F00D);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin step(); ok = ctrl_req_o; end
      chk("t6_granted", ok, 1);
      repeat (2) step();
      #2 reset_n_i = 1'b0;
      #1;
      chk("t6_rst_req", ctrl_req_o, 0);
      chk("t6_rst_we", ctrl_we_o, 0);
      chk("t6_rst_addr", ctrl_addr_o, 0);
      chk("t6_rst_wdata", ctrl_wdata_o, 0);
      chk("t6_rst_be", ctrl_be_o, 0);
      chk("t6_rst_acks", {vid_ack_o, cpu_ack_o}, 2'b00);
      chk("t6_rst_rdata", {vid_rdata_o, cpu_rdata_o}, 64'h0);
      cpu_req_i = 1'b0;
      repeat (2) step();
      reset_n_i = 1'b1;
      repeat (12) step();
      chk("t6_no_ack", clog.size(), nc);
      lat = 3;
      rdq.push_back(32'h4444_4444);
      cpu_cmd(1'b0, 24'h000600, 32'h0);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin step(); ok = cpu_ack_o; end
      chk("t6_new_acked", ok, 1);
      chk("t6_new_rdata", cpu_rdata_o, 32'h4444_4444);
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
